core_pipe_decode_buf: RTL
=========================

# core_pipe_decode_buf

Parametrised decode/operand-gather stage with a registered, handshaked output and an optional one-entry skid buffer.
- Takes a pre-decoded instruction from fetch/decode (stage 1): operand-select vectors, immediates, register addresses.
- Gathers operands A/B/C from forwarded register data, PC, NPC and immediates.
- Holds the result in the stage-2 pipeline register until execute accepts it.
- Adds what a plain decode stage lacks: valid/ready flow control, load-use interlock, flush, a saturating interlock-stall counter, and XLEN/address-width generality.

## Interface
Parameters:
- XLEN, 64, datapath width; XL = XLEN-1.
- RA_W, 5, register address width.
- UOP_W, 8, opaque micro-op field width, passed through unchanged.
- SKID, 1, 1 = one-entry skid buffer with registered `s1_ready`; 0 = no skid, combinational ready.
- CNT_W, 16, width of the stall counter.

Ports:
- Clocking and reset: one clock; reset is asynchronous and active-high.
  - g_clk  in  1  global clock.
  - g_reset  in  1  global reset, asynchronous, active-high.
- Stage-1 input (decode → this block):
  - s1_valid  in  1  stage-1 instruction valid.
  - s1_ready  out  1  block accepts the stage-1 instruction this cycle.
  - s1_16bit  in  1  compressed instruction (else 32-bit).
  - s1_pc, s1_npc  in  XLEN  PC and next PC.
  - s1_imm_b, s1_imm_c  in  XLEN  operand-B and operand-C immediates.
  - s1_sel_a  in  2  one-hot {pc, rs1}.
  - s1_sel_b  in  2  one-hot {imm, rs2}.
  - s1_sel_c  in  3  one-hot {npc, imm, rs2}.
  - s1_rs1_addr, s1_rs2_addr  in  RA_W  source register addresses.
  - s1_rs1_en, s1_rs2_en  in  1  source register actually read.
  - s1_rd  in  RA_W  destination register.
  - s1_uop  in  UOP_W  micro-op.
- Fetch consumption:
  - s2_eat_2, s2_eat_4  out  1  fetch buffer consumption pulses.
- Register file read (data arrives already forwarded, same cycle):
  - s2_rs1_addr, s2_rs2_addr  out  RA_W  register read addresses.
  - s2_rs1_data, s2_rs2_data  in  XLEN  forwarded read data.
- Load-use hazard source:
  - s3_load_valid  in  1  execute stage holds a load.
  - s3_load_rd  in  RA_W  that load's destination register.
- Flush:
  - flush  in  1  kill all held and incoming instructions.
- Stage-2 output (this block → execute):
  - s2_valid  out  1  output register valid.
  - s2_ready  in  1  execute consumes the output this cycle.
  - s2_opr_a, s2_opr_b, s2_opr_c  out  XLEN  gathered operands.
  - s2_rd  out  RA_W  destination register.
  - s2_uop  out  UOP_W  micro-op.
- Performance:
  - stall_cnt  out  CNT_W  saturating count of interlock cycles.

## Operation
Register read addresses:
- `s2_rs1_addr`/`s2_rs2_addr` = `s1_rs1_addr`/`s1_rs2_addr`, combinational.

Hazard:
- hazard = s1_valid & s3_load_valid & (s3_load_rd != 0) & ((s1_rs1_en & s1_rs1_addr == s3_load_rd) | (s1_rs2_en & s1_rs2_addr == s3_load_rd)).

Ready and accept:
- SKID=0: s1_ready = !flush & !hazard & (!s2_valid | s2_ready).
- SKID=1: s1_ready = !flush & !hazard & !skid_valid; `skid_valid` is a register.
- accept = s1_valid & s1_ready.

Operand gather (captured only on accept):
- opr_a = {XLEN{sel_a[0]}} & rs1_data | {XLEN{sel_a[1]}} & pc.
- opr_b = {XLEN{sel_b[0]}} & rs2_data | {XLEN{sel_b[1]}} & imm_b.
- opr_c = rs2_data / imm_c / npc, AND-OR selected the same way.
- An all-zero select vector yields 0.
- Multiple set bits are OR-combined; no check is made.

Destination of an accepted entry:
- Output register, if it is empty or draining this cycle (`s2_ready`).
- Otherwise the skid entry (SKID=1 only).
- On drain, if the skid entry is valid it moves to the output register and `skid_valid` clears.

Fetch consumption:
- s2_eat_2 = accept & s1_16bit.
- s2_eat_4 = accept & !s1_16bit.
- At most one is high; both are 0 when not accepting.

Flush (synchronous):
- Next cycle: s2_valid = 0, skid_valid = 0.
- Nothing is accepted during a flush cycle.
- Flush overrides a simultaneous accept or drain.

Stall counter:
- Increments each cycle that (s1_valid & hazard & !flush).
- Saturates at 2^CNT_W-1; never wraps.

## Timing
- Latency: accept in cycle N → s2_valid with that entry's fields in cycle N+1.
- Throughput: one instruction per cycle while `s2_ready` stays high.
- SKID=1 under backpressure:
  - Output held, one extra instruction is accepted into the skid entry.
  - s1_ready falls the following cycle.
  - After the first drain, the skid entry moves to the output; s1_ready rises one cycle later.
- Output stability: the output register and its fields are stable while s2_valid & !s2_ready.
- Reset (async assert, applies immediately):
  - s2_valid = 0, skid_valid = 0, stall_cnt = 0.
  - s2_opr_a/b/c = 0, s2_rd = 0, s2_uop = 0.
  - Combinational outputs follow their inputs: s1_ready = !flush & !hazard, eat pulses per accept.
- Reset mid-operation: in-flight entries are discarded with no drain.

## Test plan
- Streaming:
  - Stimulus: 4 back-to-back 32-bit ADDs, s2_ready = 1, sel_a=rs1, sel_b=rs2, rs1_data=5, rs2_data=7.
  - Response: s2_valid from cycle 1 through 4, opr_a=5, opr_b=7, s2_eat_4 high 4 cycles, s2_eat_2 never high.
- JAL gather:
  - Stimulus: sel_a=pc, sel_b=imm, sel_c=npc, pc=0x1000, npc=0x1004, imm_b=0x20.
  - Response: opr_a=0x1000, opr_b=0x20, opr_c=0x1004.
- Load-use interlock:
  - Stimulus: s3_load_valid=1, s3_load_rd=3, s1_rs2_en=1, s1_rs2_addr=3, held 2 cycles.
  - Response: s1_ready=0, no eat pulses, stall_cnt=2.
  - Stimulus: same with s3_load_rd=0 → s1_ready=1.
- Backpressure (SKID=1):
  - Stimulus: s2_ready=0 for 3 cycles with s1_valid=1.
  - Response: exactly 2 accepts, s1_ready=0 from the 3rd cycle.
  - Stimulus: release s2_ready → the two entries emerge in order, s1_ready=1 one cycle after the first drain.
- Flush:
  - Stimulus: output and skid both full, assert flush together with s1_valid.
  - Response: s2_valid=0 and skid empty next cycle, no eat pulse in the flush cycle.
- Saturation and reset:
  - Stimulus: CNT_W=2, hazard held 6 cycles.
  - Response: stall_cnt=3.
  - Stimulus: async g_reset pulse mid-cycle.
  - Response: s2_valid=0, stall_cnt=0, operands 0 before the next clock edge.

Source files
------------

// File: rtl/core_pipe_decode_buf.sv
// rtl/core_pipe_decode_buf.sv - decode/operand-gather stage with handshaked output register and optional skid entry
module core_pipe_decode_buf #(
   parameter int XLEN  = 64,
   parameter int RA_W  = 5,
   parameter int UOP_W = 8,
   parameter int SKID  = 1,
   parameter int CNT_W = 16
) (
   input  logic             g_clk,
   input  logic             g_reset,
   input  logic             s1_valid,
   output logic             s1_ready,
   input  logic             s1_16bit,
   input  logic [XLEN-1:0]  s1_pc,
   input  logic [XLEN-1:0]  s1_npc,
   input  logic [XLEN-1:0]  s1_imm_b,
   input  logic [XLEN-1:0]  s1_imm_c,
   input  logic [1:0]       s1_sel_a,
   input  logic [1:0]       s1_sel_b,
   input  logic [2:0]       s1_sel_c,
   input  logic [RA_W-1:0]  s1_rs1_addr,
   input  logic [RA_W-1:0]  s1_rs2_addr,
   input  logic             s1_rs1_en,
   input  logic             s1_rs2_en,
   input  logic [RA_W-1:0]  s1_rd,
   input  logic [UOP_W-1:0] s1_uop,
   output logic             s2_eat_2,
   output logic             s2_eat_4,
   output logic [RA_W-1:0]  s2_rs1_addr,
   output logic [RA_W-1:0]  s2_rs2_addr,
   input  logic [XLEN-1:0]  s2_rs1_data,
   input  logic [XLEN-1:0]  s2_rs2_data,
   input  logic             s3_load_valid,
   input  logic [RA_W-1:0]  s3_load_rd,
   input  logic             flush,
   output logic             s2_valid,
   input  logic             s2_ready,
   output logic [XLEN-1:0]  s2_opr_a,
   output logic [XLEN-1:0]  s2_opr_b,
   output logic [XLEN-1:0]  s2_opr_c,
   output logic [RA_W-1:0]  s2_rd,
   output logic [UOP_W-1:0] s2_uop,
   output logic [CNT_W-1:0] stall_cnt
);

   localparam int XL = XLEN - 1;
   localparam logic [CNT_W-1:0] CNT_MAX = '1;

   logic          hazard;
   logic          accept;
   logic          out_free;
   logic          skid_valid;
   logic [XL:0]   opr_a;
   logic [XL:0]   opr_b;
   logic [XL:0]   opr_c;
   logic [XL:0]   skid_a;
   logic [XL:0]   skid_b;
   logic [XL:0]   skid_c;
   logic [RA_W-1:0]  skid_rd;
   logic [UOP_W-1:0] skid_uop;

   assign s2_rs1_addr = s1_rs1_addr;
   assign s2_rs2_addr = s1_rs2_addr;

   // Writes to x0 never create a load-use dependency.
   assign hazard = s1_valid & s3_load_valid & (s3_load_rd != '0) &
                   ((s1_rs1_en & (s1_rs1_addr == s3_load_rd)) |
                    (s1_rs2_en & (s1_rs2_addr == s3_load_rd)));

   assign out_free = !s2_valid | s2_ready;

   always_comb begin
      s1_ready = 1'b0;
      if (SKID != 0)
         s1_ready = !flush & !hazard & !skid_valid;
      else
         s1_ready = !flush & !hazard & out_free;
   end

   assign accept   = s1_valid & s1_ready;
   assign s2_eat_2 = accept & s1_16bit;
   assign s2_eat_4 = accept & !s1_16bit;

   assign opr_a = ({XLEN{s1_sel_a[0]}} & s2_rs1_data) |
                  ({XLEN{s1_sel_a[1]}} & s1_pc);
   assign opr_b = ({XLEN{s1_sel_b[0]}} & s2_rs2_data) |
                  ({XLEN{s1_sel_b[1]}} & s1_imm_b);
   assign opr_c = ({XLEN{s1_sel_c[0]}} & s2_rs2_data) |
                  ({XLEN{s1_sel_c[1]}} & s1_imm_c) |
                  ({XLEN{s1_sel_c[2]}} & s1_npc);

   always_ff @(posedge g_clk or posedge g_reset) begin
      if (g_reset) begin
         s2_valid   <= 1'b0;
         skid_valid <= 1'b0;
         s2_opr_a   <= '0;
         s2_opr_b   <= '0;
         s2_opr_c   <= '0;
         s2_rd      <= '0;
         s2_uop     <= '0;
         skid_a     <= '0;
         skid_b     <= '0;
         skid_c     <= '0;
         skid_rd    <= '0;
         skid_uop   <= '0;
      end else if (flush) begin
         s2_valid   <= 1'b0;
         skid_valid <= 1'b0;
      end else if (out_free) begin
         // An occupied skid entry is always older than anything on s1.
         if (skid_valid) begin
            s2_valid   <= 1'b1;
            skid_valid <= 1'b0;
            s2_opr_a   <= skid_a;
            s2_opr_b   <= skid_b;
            s2_opr_c   <= skid_c;
            s2_rd      <= skid_rd;
            s2_uop     <= skid_uop;
         end else if (accept) begin
            s2_valid   <= 1'b1;
            s2_opr_a   <= opr_a;
            s2_opr_b   <= opr_b;
            s2_opr_c   <= opr_c;
            s2_rd      <= s1_rd;
            s2_uop     <= s1_uop;
         end else begin
            s2_valid   <= 1'b0;
         end
      end else if (accept && (SKID != 0)) begin
         skid_valid <= 1'b1;
         skid_a     <= opr_a;
         skid_b     <= opr_b;
         skid_c     <= opr_c;
         skid_rd    <= s1_rd;
         skid_uop   <= s1_uop;
      end
   end

   always_ff @(posedge g_clk or posedge g_reset) begin
      if (g_reset)
         stall_cnt <= '0;
      else if (hazard && !flush && (stall_cnt != CNT_MAX))
         stall_cnt <= stall_cnt + CNT_W'(1);
   end

endmodule
